// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bit stream out,
// with a one-word holding register for gapless streaming. Define SER_PARITY_EN to append an even-parity bit.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             accept_s;
  logic             last_s;
  logic             load_s;
  logic [WIDTH-1:0] load_word_s;
  logic             shift_in_s;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  assign accept_s = valid && !hold_full_q;
  assign last_s   = (state_q == S_SHIFT) && (cnt_q == CNT_ZERO);

  // The parity bit enters at bit 0 on every shift so it reaches the MSB exactly one cycle after the LSB.
`ifdef SER_PARITY_EN
  assign shift_in_s = par_q;
`else
  assign shift_in_s = 1'b0;
`endif

  // Next-state logic: routing of accepted words, shifting and hold transfer
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load_s      = 1'b0;
    load_word_s = data_in;
`ifdef SER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          load_s      = 1'b1;
          load_word_s = data_in;
        end else begin
          load_s      = 1'b0;
        end
      end
      S_SHIFT: begin
        if (last_s) begin
          if (hold_full_q) begin
            load_s      = 1'b1;
            load_word_s = hold_q;
            hold_full_d = 1'b0;
          end else if (accept_s) begin
            load_s      = 1'b1;
            load_word_s = data_in;
          end else begin
            state_d = S_IDLE;
            sh_d    = {WIDTH{1'b0}};
          end
        end else begin
          sh_d  = {sh_q[WIDTH-2:0], shift_in_s};
          cnt_d = cnt_q - CNT_ONE;
          if (accept_s) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        sh_d        = {WIDTH{1'b0}};
        cnt_d       = CNT_ZERO;
        hold_full_d = 1'b0;
      end
    endcase
    if (load_s) begin
      sh_d    = load_word_s;
      cnt_d   = LAST_CNT;
      state_d = S_SHIFT;
`ifdef SER_PARITY_EN
      par_d   = even_parity(load_word_s);
`endif
    end else begin
      state_d = state_d;
    end
  end

  // State, shifter and holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sh_q        <= {WIDTH{1'b0}};
      cnt_q       <= CNT_ZERO;
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`ifdef SER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Outputs decode flops only, so an asynchronous reset clears them at once.
  assign ready      = !hold_full_q;
  assign dout_valid = (state_q == S_SHIFT);
  assign dout       = (state_q == S_SHIFT) ? sh_q[WIDTH-1] : 1'b0;
  assign frame_done = last_s;
  assign busy       = (state_q == S_SHIFT) || hold_full_q;

endmodule
